gf_serial_mulred: RTL

GF_SERIAL_MULRED -- requirements
Module: gf_serial_mulred

---
 rtl/gf_serial_mulred.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/gf_serial_mulred.sv
// gf_serial_mulred -- bit-serial GF(2^m) adder / multiplier with polynomial
// reduction. Operands, reduction polynomial and field degree arrive serially
// (MSB first) during a LOAD phase, the result is computed either in one cycle
// (XOR, or illegal grade) or with an interleaved MSB-first shift-and-add
// multiply over m cycles, and finally shifted out MSB first.
//
// Ports:
//   clk           - sole clock, rising edge
//   resetn        - asynchronous active-low reset
//   enable        - global clock enable; low freezes all state and outputs
//   start         - begin a transaction (sampled only in IDLE)
//   op            - 0 = GF add (XOR), 1 = GF multiply with reduction
//   in_a, in_b    - serial operand lanes, MSB first
//   polyn_red_in  - serial reduction polynomial, DATA_WIDTH+1 bits, MSB first
//   polyn_grade   - serial field degree m, GW bits, MSB first
//   out_serial    - result bit, MSB first (0 when out_valid is low)
//   out_valid     - high while out_serial carries a result bit
//   busy          - high in any state other than IDLE
//   done          - one-cycle pulse after the last result bit
//   err           - illegal-grade flag for the current/last transaction
module gf_serial_mulred #(
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic start,
  input  logic op,
  input  logic in_a,
  input  logic in_b,
  input  logic polyn_red_in,
  input  logic polyn_grade,
  output logic out_serial,
  output logic out_valid,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int GW       = $clog2(DATA_WIDTH) + 1;
  localparam int LOAD_LEN = DATA_WIDTH + 1;
  localparam int AW       = DATA_WIDTH + 1;
  // One counter serves load, compute and shift-out; it must reach DATA_WIDTH.
  localparam int CW       = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, SHIFT_OUT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH-1:0] out_reg;
  logic [AW-1:0]         p_reg;
  logic [AW-1:0]         acc;
  logic [GW-1:0]         g_reg;
  logic [CW-1:0]         cnt;
  logic                  op_reg;

  logic [GW-1:0]         g_nxt;
  logic                  grade_bad;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] xor_res;
  logic [DATA_WIDTH-1:0] mul_res;
  logic [AW-1:0]         a_ext;
  logic                  b_bit;
  logic [AW-1:0]         acc_step;

  // Bits [m-1:0] set; all ones when m covers the full operand width.
  function automatic logic [DATA_WIDTH-1:0] grade_mask(input logic [GW-1:0] m);
    if (m >= GW'(DATA_WIDTH)) return '1;
    return (DATA_WIDTH'(1) << m) - DATA_WIDTH'(1);
  endfunction

  // One step of the interleaved multiply: shift, reduce on overflow into
  // bit m, then conditionally add the multiplicand.
  function automatic logic [AW-1:0] mul_step(input logic [AW-1:0] acc_in,
                                             input logic [AW-1:0] poly,
                                             input logic [AW-1:0] a_in,
                                             input logic          b_in,
                                             input logic [GW-1:0] m);
    logic [AW-1:0] t;
    t = acc_in << 1;
    if (|(t & (AW'(1) << m))) t = t ^ poly;
    if (b_in) t = t ^ a_in;
    return t;
  endfunction

  // The grade is checked on the same edge that shifts in its last bit, so the
  // check looks at the value the register is about to hold.
  assign g_nxt     = {g_reg[GW-2:0], polyn_grade};
  assign grade_bad = (g_nxt < GW'(2)) || (g_nxt > GW'(DATA_WIDTH));

  assign mask     = grade_mask(g_reg);
  assign xor_res  = (a_reg ^ b_reg) & mask;
  assign a_ext    = {1'b0, a_reg & mask};
  assign b_bit    = |(b_reg & (DATA_WIDTH'(1) << cnt));
  assign acc_step = mul_step(acc, p_reg, a_ext, b_bit, g_reg);
  assign mul_res  = acc_step[DATA_WIDTH-1:0] & mask;

  // out_reg is all zeros outside SHIFT_OUT, so its MSB is 0 whenever
  // out_valid is low.
  assign out_serial = out_reg[DATA_WIDTH-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= '0;
      g_reg     <= '0;
      acc       <= '0;
      out_reg   <= '0;
      cnt       <= '0;
      op_reg    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          // A start coinciding with the done pulse is dropped so that
          // consecutive transactions always see an IDLE gap.
          if (start && !done) begin
            state  <= LOAD;
            busy   <= 1'b1;
            op_reg <= op;
            err    <= 1'b0;
            cnt    <= '0;
          end
        end

        LOAD: begin
          a_reg <= {a_reg[DATA_WIDTH-2:0], in_a};
          b_reg <= {b_reg[DATA_WIDTH-2:0], in_b};
          p_reg <= {p_reg[AW-2:0], polyn_red_in};
          g_reg <= g_nxt;
          if (cnt == CW'(LOAD_LEN - 1)) begin
            state <= COMPUTE;
            err   <= grade_bad;
            acc   <= '0;
            cnt   <= CW'(g_nxt - GW'(1));
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        COMPUTE: begin
          if (err || !op_reg) begin
            out_reg   <= err ? '0 : xor_res;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= SHIFT_OUT;
          end else begin
            // cnt walks b from bit m-1 down to bit 0.
            acc <= acc_step;
            if (cnt == '0) begin
              out_reg   <= mul_res;
              out_valid <= 1'b1;
              state     <= SHIFT_OUT;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end

        SHIFT_OUT: begin
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b1;
            out_reg   <= '0;
            cnt       <= '0;
          end else begin
            out_reg <= out_reg << 1;
            cnt     <= cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
